// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared definitions for the per-game timer.
//   state_e        game state encoding driven onto game_timer.state_o
//   SEC_PER_MIN    seconds per display minute
//   limit_seconds  game time limit in seconds for a given minute limit
// Optional feature macro used by this slice: GAME_TIMER_BCD_EN.
package game_timer_pkg;

  localparam int unsigned SEC_PER_MIN = 60;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StDone    = 2'd3
  } state_e;

  function automatic int unsigned limit_seconds(input int unsigned minutes);
    return minutes * SEC_PER_MIN;
  endfunction

endpackage

// File: rtl/bcd_split.sv
// bcd_split: converts a binary value 0..99 into two BCD digits.
//   bin_i  binary input, 0..99
//   bcd_o  {tens, ones} BCD digits
// Only present when GAME_TIMER_BCD_EN is defined.
`ifdef GAME_TIMER_BCD_EN
module bcd_split (
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o
);

  always_comb begin
    bcd_o[7:4] = 4'(bin_i / 7'd10);
    bcd_o[3:0] = 4'(bin_i % 7'd10);
  end

endmodule
`endif

// File: rtl/game_timer.sv
// game_timer: per-game timer on the 1 Hz tick with up/down display modes,
// pause/resume, solve capture, expiry and warning flags, and a best-time
// register that persists across games (cleared only by reset).
//   clk_1Hz          1 Hz tick clock
//   reset            asynchronous active-high reset
//   start_i          begin a new game (IDLE or DONE only)
//   count_down_i     display mode, latched on an accepted start
//   run_i            level: 1 = count, 0 = pause
//   solved_i         puzzle solved (RUNNING or PAUSED only)
//   clear_i          abandon the game, return to IDLE
//   state_o          IDLE=0, RUNNING=1, PAUSED=2, DONE=3
//   elapsed_o        seconds played in the current game
//   minutes_o        display minutes (elapsed or remaining)
//   seconds_o        display seconds 0..59
//   expired_o        game ended by reaching the limit
//   warn_o           remaining time <= WARN_SECONDS while RUNNING/PAUSED
//   best_seconds_o   lowest elapsed over solved games
//   best_valid_o     best_seconds_o holds a real result
//   min_bcd_o        BCD display minutes (GAME_TIMER_BCD_EN only)
//   sec_bcd_o        BCD display seconds (GAME_TIMER_BCD_EN only)
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned MAX_MINUTES  = 30,
  parameter int unsigned WARN_SECONDS = 60,
  localparam int unsigned LIMIT   = limit_seconds(MAX_MINUTES),
  localparam int unsigned TOTAL_W = $clog2(LIMIT + 1),
  localparam int unsigned MIN_W   = $clog2(MAX_MINUTES + 1)
) (
  input  logic               clk_1Hz,
  input  logic               reset,
`ifdef GAME_TIMER_BCD_EN
  output logic [7:0]         min_bcd_o,
  output logic [7:0]         sec_bcd_o,
`endif
  input  logic               start_i,
  input  logic               count_down_i,
  input  logic               run_i,
  input  logic               solved_i,
  input  logic               clear_i,
  output logic [1:0]         state_o,
  output logic [TOTAL_W-1:0] elapsed_o,
  output logic [MIN_W-1:0]   minutes_o,
  output logic [5:0]         seconds_o,
  output logic               expired_o,
  output logic               warn_o,
  output logic [TOTAL_W-1:0] best_seconds_o,
  output logic               best_valid_o
);

  localparam logic [TOTAL_W-1:0] LimitW  = TOTAL_W'(LIMIT);
  localparam logic [TOTAL_W-1:0] WarnW   = TOTAL_W'(WARN_SECONDS);
  localparam logic [MIN_W-1:0]   MaxMinW = MIN_W'(MAX_MINUTES);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [TOTAL_W-1:0]   elapsed_q, elapsed_d;
  logic [MIN_W-1:0]     min_q, min_d;
  logic [5:0]           sec_q, sec_d;
  logic                 expired_q, expired_d;
  logic                 warn_q, warn_d;
  logic [TOTAL_W-1:0]   best_q, best_d;
  logic                 best_valid_q, best_valid_d;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    elapsed_d    = elapsed_q;
    min_d        = min_q;
    sec_d        = sec_q;
    expired_d    = expired_q;
    best_d       = best_q;
    best_valid_d = best_valid_q;

    if (clear_i) begin
      state_d   = StIdle;
      elapsed_d = '0;
      min_d     = '0;
      sec_d     = '0;
      expired_d = 1'b0;
    end else if (start_i && (state_q == StIdle || state_q == StDone)) begin
      mode_d    = count_down_i;
      elapsed_d = '0;
      expired_d = 1'b0;
      min_d     = count_down_i ? MaxMinW : '0;
      sec_d     = '0;
      state_d   = run_i ? StRunning : StPaused;
    end else if (solved_i && (state_q == StRunning || state_q == StPaused)) begin
      state_d   = StDone;
      expired_d = 1'b0;
      if (!best_valid_q || elapsed_q < best_q) begin
        best_d       = elapsed_q;
        best_valid_d = 1'b1;
      end
    end else if (state_q == StRunning) begin
      if (run_i) begin
        elapsed_d = elapsed_q + TOTAL_W'(1);
        if (mode_q) begin
          if (sec_q == 6'd0) begin
            sec_d = 6'd59;
            min_d = min_q - MIN_W'(1);
          end else begin
            sec_d = sec_q - 6'd1;
          end
        end else begin
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            min_d = min_q + MIN_W'(1);
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        // Reaching the limit ends the game; counting stops here so elapsed never passes LIMIT.
        if (elapsed_d == LimitW) begin
          state_d   = StDone;
          expired_d = 1'b1;
          min_d     = mode_q ? '0 : MaxMinW;
          sec_d     = '0;
        end
      end else begin
        state_d = StPaused;
      end
    end else if (state_q == StPaused && run_i) begin
      state_d = StRunning;
    end

    // Computed from post-edge values so warn rises on the edge remaining hits the threshold.
    warn_d = (state_d == StRunning || state_d == StPaused) && ((LimitW - elapsed_d) <= WarnW);
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      elapsed_q    <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      expired_q    <= 1'b0;
      warn_q       <= 1'b0;
      best_q       <= '1;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      elapsed_q    <= elapsed_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      expired_q    <= expired_d;
      warn_q       <= warn_d;
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign state_o        = state_q;
  assign elapsed_o      = elapsed_q;
  assign minutes_o      = min_q;
  assign seconds_o      = sec_q;
  assign expired_o      = expired_q;
  assign warn_o         = warn_q;
  assign best_seconds_o = best_q;
  assign best_valid_o   = best_valid_q;

`ifdef GAME_TIMER_BCD_EN
  logic [7:0] min_bcd_d, sec_bcd_d, min_bcd_q, sec_bcd_q;

  // Fed from next-state display values so BCD updates on the same edge as minutes/seconds.
  bcd_split u_min_bcd (
    .bin_i(7'(min_d)),
    .bcd_o(min_bcd_d)
  );

  bcd_split u_sec_bcd (
    .bin_i(7'(sec_d)),
    .bcd_o(sec_bcd_d)
  );

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      min_bcd_q <= 8'h00;
      sec_bcd_q <= 8'h00;
    end else begin
      min_bcd_q <= min_bcd_d;
      sec_bcd_q <= sec_bcd_d;
    end
  end

  assign min_bcd_o = min_bcd_q;
  assign sec_bcd_o = sec_bcd_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed test-plan sequence followed by random stimulus,
// all checked against a behavioural model of the game rules.
module tb_game_timer;

  localparam int unsigned MaxMin = 2;
  localparam int unsigned Warn   = 10;
  localparam int          Limit  = 120;
  localparam int unsigned TotW   = 7;
  localparam int unsigned MinW   = 2;

  logic            clk_1Hz;
  logic            reset;
  logic            start_i, count_down_i, run_i, solved_i, clear_i;
  logic [1:0]      state_o;
  logic [TotW-1:0] elapsed_o;
  logic [MinW-1:0] minutes_o;
  logic [5:0]      seconds_o;
  logic            expired_o, warn_o;
  logic [TotW-1:0] best_seconds_o;
  logic            best_valid_o;
`ifdef GAME_TIMER_BCD_EN
  logic [7:0]      min_bcd_o, sec_bcd_o;
`endif

  int tests;
  int failed;

  // Reference model state: plain integers.
  int m_st, m_mode, m_el, m_exp, m_best, m_bv;

  game_timer #(
    .MAX_MINUTES (MaxMin),
    .WARN_SECONDS(Warn)
  ) dut (
    .clk_1Hz       (clk_1Hz),
    .reset         (reset),
`ifdef GAME_TIMER_BCD_EN
    .min_bcd_o     (min_bcd_o),
    .sec_bcd_o     (sec_bcd_o),
`endif
    .start_i       (start_i),
    .count_down_i  (count_down_i),
    .run_i         (run_i),
    .solved_i      (solved_i),
    .clear_i       (clear_i),
    .state_o       (state_o),
    .elapsed_o     (elapsed_o),
    .minutes_o     (minutes_o),
    .seconds_o     (seconds_o),
    .expired_o     (expired_o),
    .warn_o        (warn_o),
    .best_seconds_o(best_seconds_o),
    .best_valid_o  (best_valid_o)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_mode = 0; m_el = 0; m_exp = 0;
    m_best = (1 << TotW) - 1; m_bv = 0;
  endtask

  task automatic model_edge(input int s, input int cd, input int r, input int sv, input int cl);
    if (cl != 0) begin
      m_st = 0; m_el = 0; m_exp = 0;
    end else if (s != 0 && (m_st == 0 || m_st == 3)) begin
      m_mode = cd; m_el = 0; m_exp = 0;
      m_st = (r != 0) ? 1 : 2;
    end else if (sv != 0 && (m_st == 1 || m_st == 2)) begin
      m_st = 3; m_exp = 0;
      if (m_bv == 0 || m_el < m_best) begin
        m_best = m_el; m_bv = 1;
      end
    end else if (m_st == 1) begin
      if (r != 0) begin
        m_el++;
        if (m_el == Limit) begin
          m_st = 3; m_exp = 1;
        end
      end else begin
        m_st = 2;
      end
    end else if (m_st == 2 && r != 0) begin
      m_st = 1;
    end
  endtask

  function automatic int disp_val();
    if (m_st == 0) return 0;
    return (m_mode != 0) ? (Limit - m_el) : m_el;
  endfunction

  function automatic int m_warn();
    return ((m_st == 1 || m_st == 2) && (Limit - m_el) <= int'(Warn)) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"},   32'(state_o),        m_st);
    chk({tag, ".elapsed"}, 32'(elapsed_o),      m_el);
    chk({tag, ".minutes"}, 32'(minutes_o),      disp_val() / 60);
    chk({tag, ".seconds"}, 32'(seconds_o),      disp_val() % 60);
    chk({tag, ".expired"}, 32'(expired_o),      m_exp);
    chk({tag, ".warn"},    32'(warn_o),         m_warn());
    chk({tag, ".best"},    32'(best_seconds_o), m_best);
    chk({tag, ".bvalid"},  32'(best_valid_o),   m_bv);
  endtask

  task automatic step(input string tag, input logic s, input logic cd, input logic r,
                      input logic sv, input logic cl);
    start_i = s; count_down_i = cd; run_i = r; solved_i = sv; clear_i = cl;
    @(posedge clk_1Hz);
    model_edge(int'(s), int'(cd), int'(r), int'(sv), int'(cl));
    #1;
    check_all(tag);
  endtask

  task automatic run_n(input string tag, input int n, input logic r);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, r, 1'b0, 1'b0);
  endtask

  initial begin
    tests = 0; failed = 0;
    start_i = 0; count_down_i = 0; run_i = 0; solved_i = 0; clear_i = 0;
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    #1;

    // Up mode: 30 counting edges after the start edge.
    step("up_start", 1, 0, 1, 0, 0);
    run_n("up_run", 30, 1);
    chk("up30.elapsed", 32'(elapsed_o), 30);
    chk("up30.seconds", 32'(seconds_o), 30);
    chk("up30.state",   32'(state_o),   1);

    // Up mode to the limit, then frozen in DONE.
    run_n("up_run", 90, 1);
    chk("up_limit.state",   32'(state_o),   3);
    chk("up_limit.expired", 32'(expired_o), 1);
    chk("up_limit.minutes", 32'(minutes_o), 2);
    run_n("done_hold", 5, 1);
    chk("done_hold.elapsed", 32'(elapsed_o), 120);

    // Down mode from DONE.
    step("dn_start", 1, 1, 1, 0, 0);
    chk("dn_start.minutes", 32'(minutes_o), 2);
    step("dn_run", 0, 0, 1, 0, 0);
    chk("dn1.seconds", 32'(seconds_o), 59);
    run_n("dn_run", 109, 1);
    chk("dn110.seconds", 32'(seconds_o), 10);
    chk("dn110.warn",    32'(warn_o),    1);

    // Pause and resume.
    step("pz_clear", 0, 0, 0, 0, 1);
    step("pz_start", 1, 0, 1, 0, 0);
    run_n("pz_run", 45, 1);
    run_n("pz_pause", 10, 0);
    chk("pz_pause.state",   32'(state_o),   2);
    chk("pz_pause.elapsed", 32'(elapsed_o), 45);
    step("pz_resume", 0, 0, 1, 0, 0);
    chk("pz_resume.elapsed", 32'(elapsed_o), 45);
    step("pz_next", 0, 0, 1, 0, 0);
    chk("pz_next.elapsed", 32'(elapsed_o), 46);

    // Best time across games; ties and slower results do not update.
    step("bt_clear", 0, 0, 0, 0, 1);
    step("bt_start1", 1, 0, 1, 0, 0);
    run_n("bt_run1", 50, 1);
    step("bt_solve1", 0, 0, 1, 1, 0);
    chk("bt1.best", 32'(best_seconds_o), 50);
    step("bt_start2", 1, 0, 1, 0, 0);
    run_n("bt_run2", 70, 1);
    step("bt_solve2", 0, 0, 1, 1, 0);
    chk("bt2.best", 32'(best_seconds_o), 50);
    step("bt_start3", 1, 0, 1, 0, 0);
    run_n("bt_run3", 40, 1);
    step("bt_solve3", 0, 0, 1, 1, 0);
    chk("bt3.best", 32'(best_seconds_o), 40);
    step("bt_clear2", 0, 0, 0, 0, 1);
    chk("bt_clear.best", 32'(best_seconds_o), 40);

    // Solve on the edge that would expire.
    step("sx_start", 1, 0, 1, 0, 0);
    run_n("sx_run", 119, 1);
    step("sx_solve", 0, 0, 1, 1, 0);
    chk("sx.elapsed", 32'(elapsed_o), 119);
    chk("sx.expired", 32'(expired_o), 0);
    chk("sx.state",   32'(state_o),   3);

    // Asynchronous reset mid-game.
    step("rs_start", 1, 1, 1, 0, 0);
    run_n("rs_run", 7, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rs_async");
    #3;
    reset = 1'b0;
    #1;

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      step("rnd",
           ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           ($urandom_range(0, 999) < 6) ? 1'b1 : 1'b0,
           ($urandom_range(0, 999) < 4) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
